neuron_update_ctrl: RTL and testbench
=====================================

// Module: neuron_update_ctrl
// PURPOSE
//  Sequencer for one adder_unit neuron: queues presynaptic spike events, and for each event
//  reads weight+membrane sum, writes back the new potential, and fires/resets on threshold.
//  Sits between the event fabric / RISC-V core and adder_unit's risc_v_* port.
//  Also arbitrates core weight/potential config writes onto the same port.
// PARAMETERS
//  ADDR_WIDTH   6       adder_unit address width; MSB=1 selects membrane potential
//  DATA_WIDTH   16      weight / potential width
//  FIFO_DEPTH   4       event FIFO entries, power of 2, >=2
//  RESET_POT    16'd0   potential written back after a spike
//  REFRACT_CYC  8       refractory cycles after a spike (REFRACTORY_EN only), 0 = none
// PORTS
//  clk           in   1             clock
//  reset         in   1             synchronous, active-high
//  ev_valid      in   1             event offered
//  ev_idx        in   ADDR_WIDTH-1  presynaptic weight index
//  ev_ready      out  1             FIFO not full; push on ev_valid&&ev_ready
//  cfg_write     in   1             core write request, held until cfg_ack
//  cfg_addr      in   ADDR_WIDTH    write address (adder_unit map)
//  cfg_data      in   DATA_WIDTH    write data
//  cfg_ack       out  1             1-cycle pulse when write issued
//  au_read       out  1             -> adder_unit risc_v_read
//  au_write      out  1             -> adder_unit risc_v_write
//  au_addr       out  ADDR_WIDTH    -> adder_unit risc_v_addr
//  au_data_in    out  DATA_WIDTH    -> adder_unit risc_v_data_in
//  au_data_out   in   DATA_WIDTH    <- adder_unit risc_v_data_out
//  au_spike      in   1             <- adder_unit spike_detected
//  spike_out     out  1             1-cycle pulse per output spike
//  spike_count   out  16            output spikes since reset, saturates 16'hFFFF
//  busy          out  1             state!=IDLE or FIFO non-empty
// BEHAVIOUR
//  - Reset: FIFO empty, state IDLE, all outputs 0 except ev_ready=1; spike_count=0.
//    Reset mid-operation abandons the op; no partial write completes.
//  - FSM states IDLE, CFG, RD, WB, REFR. au_* decoded from registered state/regs:
//    au_read=(RD); au_write=(CFG|WB); else au_addr/au_data_in=0.
//  - IDLE: cfg_write has priority -> latch cfg_addr/data, go CFG. Else if FIFO non-empty ->
//    pop head into idx_q, go RD. Else stay.
//  - CFG (1 cyc): au_write=1, au_addr=cfg_addr_q, au_data_in=cfg_data_q, cfg_ack=1 -> IDLE.
//  - RD (1 cyc): au_read=1, au_addr={1'b0,idx_q}; spike_q<=au_spike at cycle end -> WB.
//  - WB (1 cyc): au_write=1, au_addr={1'b1,{ADDR_WIDTH-1{1'b0}}},
//    au_data_in = spike_q ? RESET_POT : au_data_out; spike_out=spike_q; spike_count++ if
//    spike_q. -> REFR if spike_q && REFRACT_CYC>0 (REFRACTORY_EN), else IDLE.
//  - Latency: event pushed cycle t -> RD at t+2, WB at t+3, spike_out at t+3.
//    Throughput 3 cycles/event back-to-back (IDLE,RD,WB).
//  - Arithmetic: sum is adder_unit's DATA_WIDTH modulo add; no saturation here.
//  - FIFO: push when full impossible (ev_ready=0); push and pop same cycle allowed
//    when non-empty, count unchanged; pointers wrap mod FIFO_DEPTH.
//  - cfg_write arriving in RD/WB waits; serviced at next IDLE before queued events.
// CONFIGURATION
//  REFRACTORY_EN defined: REFR state counts REFRACT_CYC cycles; each REFR cycle pops and
//   discards one FIFO entry if non-empty (inputs ignored while refractory); cfg_write waits.
//   Then IDLE.
//  REFRACTORY_EN undefined: no REFR state, WB always -> IDLE, REFRACT_CYC unused.
// TESTING
//  1 Reset, cfg write addr 6'h00=16'd300, addr 6'h20=16'd0 -> cfg_ack each, au_write 1 cyc.
//  2 Potential 0, w[0]=300, 3 events idx 0 -> potential 300,600,900; spike_out never; 9 cycles.
//  3 Potential 900, event idx 0 (w=300) -> RD sees au_spike=1, WB writes RESET_POT,
//    spike_out pulse at t+3, spike_count=1.
//  4 Push 5 events back-to-back with FIFO_DEPTH=4 while busy -> ev_ready drops at full,
//    no loss; all accepted events processed in order.
//  5 REFRACTORY_EN, REFRACT_CYC=8: spike then 3 queued events -> all 3 discarded,
//    potential stays RESET_POT; without macro -> all 3 accumulated.
//  6 cfg_write raised during RD -> cfg_ack only after WB, before next queued event;
//    reset asserted during RD -> no au_write next cycle, FIFO empty.

Source files
------------

// File: rtl/neuron_update_ctrl_if.sv
// Signal bundle for neuron_update_ctrl: event input, core config writes,
// adder_unit risc_v_* port and status. master = controller side, slave = environment side.
interface neuron_update_ctrl_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
);
  logic                  ev_valid;
  logic [ADDR_WIDTH-2:0] ev_idx;
  logic                  ev_ready;

  logic                  cfg_write;
  logic [ADDR_WIDTH-1:0] cfg_addr;
  logic [DATA_WIDTH-1:0] cfg_data;
  logic                  cfg_ack;

  logic                  au_read;
  logic                  au_write;
  logic [ADDR_WIDTH-1:0] au_addr;
  logic [DATA_WIDTH-1:0] au_data_in;
  logic [DATA_WIDTH-1:0] au_data_out;
  logic                  au_spike;

  logic                  spike_out;
  logic [15:0]           spike_count;
  logic                  busy;

  modport master (
    input  ev_valid, ev_idx, cfg_write, cfg_addr, cfg_data, au_data_out, au_spike,
    output ev_ready, cfg_ack, au_read, au_write, au_addr, au_data_in,
           spike_out, spike_count, busy
  );

  modport slave (
    output ev_valid, ev_idx, cfg_write, cfg_addr, cfg_data, au_data_out, au_spike,
    input  ev_ready, cfg_ack, au_read, au_write, au_addr, au_data_in,
           spike_out, spike_count, busy
  );
endinterface

// File: rtl/neuron_update_ctrl.sv
// Event sequencer for one adder_unit neuron: queues spike events, runs read/write-back
// per event, fires on threshold, and arbitrates core config writes. Option: REFRACTORY_EN.
module neuron_update_ctrl #(
  parameter int                    ADDR_WIDTH  = 6,
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    FIFO_DEPTH  = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_POT   = '0,
  parameter int                    REFRACT_CYC = 8
) (
  input logic                  clk,
  input logic                  reset,
  neuron_update_ctrl_if.master nif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = ADDR_WIDTH - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_RD,
    S_WB
`ifdef REFRACTORY_EN
    , S_REFR
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      mem_q [FIFO_DEPTH];
  logic [IDX_W-1:0]      mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] cfg_addr_q, cfg_addr_d;
  logic [DATA_WIDTH-1:0] cfg_data_q, cfg_data_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  spike_q, spike_d;
  logic [15:0]           spike_cnt_q, spike_cnt_d;
`ifdef REFRACTORY_EN
  localparam int REFR_W = (REFRACT_CYC > 1) ? $clog2(REFRACT_CYC) : 1;
  logic [REFR_W-1:0]     refr_cnt_q, refr_cnt_d;
`endif

  logic                  fifo_full, fifo_empty, push, pop;
  logic                  au_read, au_write, cfg_ack, spike_out;
  logic [ADDR_WIDTH-1:0] au_addr;
  logic [DATA_WIDTH-1:0] au_data_in;

  assign fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign push       = nif.ev_valid && !fifo_full;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = nif.ev_idx;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cfg_addr_d  = cfg_addr_q;
    cfg_data_d  = cfg_data_q;
    idx_d       = idx_q;
    spike_d     = spike_q;
    spike_cnt_d = spike_cnt_q;
    pop         = 1'b0;
`ifdef REFRACTORY_EN
    refr_cnt_d  = refr_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        // Config writes win over queued events.
        if (nif.cfg_write) begin
          cfg_addr_d = nif.cfg_addr;
          cfg_data_d = nif.cfg_data;
          state_d    = S_CFG;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          idx_d   = mem_q[rd_ptr_q];
          state_d = S_RD;
        end
      end
      S_CFG: state_d = S_IDLE;
      S_RD: begin
        spike_d = nif.au_spike;
        state_d = S_WB;
      end
      S_WB: begin
        if (spike_q && (spike_cnt_q != '1)) begin
          spike_cnt_d = spike_cnt_q + 16'd1;
        end
        state_d = S_IDLE;
`ifdef REFRACTORY_EN
        if (spike_q && (REFRACT_CYC > 0)) begin
          refr_cnt_d = REFR_W'(REFRACT_CYC - 1);
          state_d    = S_REFR;
        end
`endif
      end
`ifdef REFRACTORY_EN
      S_REFR: begin
        // Events arriving while refractory are drained and dropped, one per cycle.
        pop = !fifo_empty;
        if (refr_cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          refr_cnt_d = refr_cnt_q - REFR_W'(1);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    au_read    = 1'b0;
    au_write   = 1'b0;
    au_addr    = '0;
    au_data_in = '0;
    cfg_ack    = 1'b0;
    spike_out  = 1'b0;
    case (state_q)
      S_CFG: begin
        au_write   = 1'b1;
        au_addr    = cfg_addr_q;
        au_data_in = cfg_data_q;
        cfg_ack    = 1'b1;
      end
      S_RD: begin
        au_read = 1'b1;
        au_addr = {1'b0, idx_q};
      end
      S_WB: begin
        au_write   = 1'b1;
        au_addr    = {1'b1, {(ADDR_WIDTH-1){1'b0}}};
        au_data_in = spike_q ? RESET_POT : nif.au_data_out;
        spike_out  = spike_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
      idx_q       <= '0;
      spike_q     <= 1'b0;
      spike_cnt_q <= '0;
`ifdef REFRACTORY_EN
      refr_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_data_q  <= cfg_data_d;
      idx_q       <= idx_d;
      spike_q     <= spike_d;
      spike_cnt_q <= spike_cnt_d;
`ifdef REFRACTORY_EN
      refr_cnt_q  <= refr_cnt_d;
`endif
    end
  end

  // Storage is only observable through the pointers, so it needs no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign nif.ev_ready    = !fifo_full;
  assign nif.cfg_ack     = cfg_ack;
  assign nif.au_read     = au_read;
  assign nif.au_write    = au_write;
  assign nif.au_addr     = au_addr;
  assign nif.au_data_in  = au_data_in;
  assign nif.spike_out   = spike_out;
  assign nif.spike_count = spike_cnt_q;
  assign nif.busy        = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_neuron_update_ctrl.sv
// Bench for neuron_update_ctrl: adder_unit stand-in, event-level reference scoreboard,
// directed scenarios and a randomized event/config stream.
module tb_neuron_update_ctrl;

  localparam int          AW     = 6;
  localparam int          DW     = 16;
  localparam int          FD     = 4;
  localparam int          RC     = 8;
  localparam logic [15:0] RP     = 16'd0;
  localparam logic [15:0] THRESH = 16'd1000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  neuron_update_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) nif ();

  neuron_update_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (FD),
    .RESET_POT  (RP),
    .REFRACT_CYC(RC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .nif  (nif)
  );

  // adder_unit stand-in: registered sum on read, combinational threshold flag
  logic [15:0] w_mem [32];
  logic [15:0] pot_mem;
  logic [15:0] dout_q;
  logic [15:0] rd_sum;
  assign rd_sum          = w_mem[nif.au_addr[4:0]] + pot_mem;
  assign nif.au_data_out = dout_q;
  assign nif.au_spike    = nif.au_read && (rd_sum >= THRESH);

  initial begin
    foreach (w_mem[i]) w_mem[i] = '0;
    pot_mem = '0;
    dout_q  = '0;
  end

  always @(posedge clk) begin
    if (nif.au_read) dout_q <= rd_sum;
    if (nif.au_write) begin
      if (nif.au_addr[5]) pot_mem <= nif.au_data_in;
      else                w_mem[nif.au_addr[4:0]] <= nif.au_data_in;
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [4:0]  q_ref [$];
  logic [15:0] w_ref [32];
  logic [15:0] pot_ref = '0;
  int          spikes_ref = 0;
  int          refr_left = 0;
  bit          wb_pend = 0;
  logic [15:0] sum_ref;
  bit          spike_ref;
  int          rd_cnt = 0;
  int          last_rd = -1, last_wb = -1, last_spike = -1, last_cfg = -1;
  bit          req_on = 0;
  logic [5:0]  req_addr;
  logic [15:0] req_data;

  initial foreach (w_ref[i]) w_ref[i] = '0;

  initial begin : monitor
    logic [4:0]  idx;
    logic [15:0] exp_pot;
    forever begin
      @(negedge clk);
      if (refr_left > 0) begin
        if (q_ref.size() > 0) void'(q_ref.pop_front());
        refr_left--;
      end
      if (nif.au_read) begin
        rd_cnt++;
        last_rd = cyc;
        if (q_ref.size() == 0) begin
          check("rd_unexpected", 1, 0);
        end else begin
          idx = q_ref.pop_front();
          check("rd_addr", 32'(nif.au_addr), 32'({1'b0, idx}));
          sum_ref   = w_ref[idx] + pot_ref;
          spike_ref = (sum_ref >= THRESH);
          wb_pend   = 1;
        end
      end else if (wb_pend) begin
        wb_pend = 0;
        last_wb = cyc;
        exp_pot = spike_ref ? RP : sum_ref;
        check("wb_write", 32'(nif.au_write), 1);
        check("wb_addr", 32'(nif.au_addr), 32'h20);
        check("wb_data", 32'(nif.au_data_in), 32'(exp_pot));
        check("wb_spike", 32'(nif.spike_out), 32'(spike_ref));
        pot_ref = exp_pot;
        if (spike_ref) begin
          spikes_ref++;
          last_spike = cyc;
`ifdef REFRACTORY_EN
          refr_left = RC;
`endif
        end
      end else begin
        check("spike_idle", 32'(nif.spike_out), 0);
        if (nif.au_write) begin
          last_cfg = cyc;
          check("cfg_req", 32'(req_on), 1);
          check("cfg_ack", 32'(nif.cfg_ack), 1);
          check("cfg_addr", 32'(nif.au_addr), 32'(req_addr));
          check("cfg_data", 32'(nif.au_data_in), 32'(req_data));
          if (req_addr[5]) pot_ref = req_data;
          else             w_ref[req_addr[4:0]] = req_data;
        end else begin
          check("cfg_ack_idle", 32'(nif.cfg_ack), 0);
        end
      end
      if (nif.ev_valid && nif.ev_ready) q_ref.push_back(nif.ev_idx);
      if (reset) begin
        q_ref.delete();
        wb_pend    = 0;
        refr_left  = 0;
        spikes_ref = 0;
      end
    end
  end

  task automatic cfg_req(input logic [5:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    req_addr = a; req_data = d; req_on = 1;
    nif.cfg_write = 1'b1; nif.cfg_addr = a; nif.cfg_data = d;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (nif.cfg_ack) break;
    end
    if (!nif.cfg_ack) check("cfg_timeout", 0, 1);
    @(posedge clk); #1;
    nif.cfg_write = 1'b0; req_on = 0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!nif.busy && !wb_pend) begin done = 1; break; end
    end
    if (!done) check("idle_timeout", 0, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin : main
    int t, rd0;
    bit saw_full;
    logic [15:0] pot_save;
    logic [15:0] exp5;
    reset = 1'b1;
    nif.ev_valid = 1'b0; nif.ev_idx = '0;
    nif.cfg_write = 1'b0; nif.cfg_addr = '0; nif.cfg_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ev_ready", 32'(nif.ev_ready), 1);
    check("rst_busy", 32'(nif.busy), 0);
    check("rst_au_read", 32'(nif.au_read), 0);
    check("rst_au_write", 32'(nif.au_write), 0);
    check("rst_cfg_ack", 32'(nif.cfg_ack), 0);
    check("rst_spike_cnt", 32'(nif.spike_count), 0);
    reset = 1'b0;

    // 1: config writes, each a single au_write cycle
    cfg_req(6'h00, 16'd300);
    @(negedge clk);
    check("t1_write_1cyc", 32'(nif.au_write), 0);
    cfg_req(6'h20, 16'd0);
    @(negedge clk);
    check("t1_write_1cyc_b", 32'(nif.au_write), 0);
    check("t1_w0", 32'(w_mem[0]), 300);
    check("t1_pot", 32'(pot_mem), 0);

    // 2: three back-to-back events accumulate, 3 cycles each
    @(posedge clk); #1;
    nif.ev_valid = 1'b1; nif.ev_idx = 5'd0; t = cyc;
    repeat (3) @(posedge clk);
    #1 nif.ev_valid = 1'b0;
    wait_idle();
    check("t2_last_rd", last_rd, t + 8);
    check("t2_last_wb", last_wb, t + 9);
    check("t2_pot", 32'(pot_mem), 900);
    check("t2_spike_cnt", 32'(nif.spike_count), 0);

    // 3: crossing threshold fires and resets
    @(posedge clk); #1;
    nif.ev_valid = 1'b1; nif.ev_idx = 5'd0; t = cyc;
    @(posedge clk); #1 nif.ev_valid = 1'b0;
    wait_idle();
    check("t3_rd_lat", last_rd, t + 2);
    check("t3_spike_lat", last_spike, t + 3);
    check("t3_pot", 32'(pot_mem), 32'(RP));
    check("t3_spike_cnt", 32'(nif.spike_count), 1);

    // 4: overfill the FIFO; backpressure, no loss, in-order
    for (int k = 1; k < 8; k++) cfg_req(6'(k), 16'(10 * k));
    cfg_req(6'h20, 16'd0);
    saw_full = 0;
    rd0 = rd_cnt;
    @(posedge clk); #1;
    for (int k = 1; k < 8; k++) begin
      nif.ev_valid = 1'b1; nif.ev_idx = 5'(k);
      for (int n = 0; n < 50; n++) begin
        @(negedge clk);
        if (nif.ev_ready) break;
        saw_full = 1;
      end
      if (!nif.ev_ready) check("t4_push_timeout", 0, 1);
      @(posedge clk); #1;
    end
    nif.ev_valid = 1'b0;
    wait_idle();
    check("t4_saw_full", 32'(saw_full), 1);
    check("t4_rd_count", rd_cnt - rd0, 7);
    check("t4_pot", 32'(pot_mem), 280);

    // 5: spike followed by queued events
    cfg_req(6'h00, 16'd300);
    cfg_req(6'h20, 16'd900);
    @(posedge clk); #1;
    nif.ev_valid = 1'b1; nif.ev_idx = 5'd0;
    repeat (4) @(posedge clk);
    #1 nif.ev_valid = 1'b0;
    wait_idle();
`ifdef REFRACTORY_EN
    exp5 = RP;
`else
    exp5 = RP + 16'd900;
`endif
    check("t5_pot", 32'(pot_mem), 32'(exp5));
    check("t5_spike_cnt", 32'(nif.spike_count), 2);

    // 6a: cfg_write raised during RD waits for WB, then precedes the queued event
    @(posedge clk); #1;
    nif.ev_valid = 1'b1; nif.ev_idx = 5'd2; t = cyc;
    @(posedge clk); #1 nif.ev_idx = 5'd3;
    @(posedge clk); #1;
    nif.ev_valid = 1'b0;
    req_addr = 6'h04; req_data = 16'd7; req_on = 1;
    nif.cfg_write = 1'b1; nif.cfg_addr = 6'h04; nif.cfg_data = 16'd7;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (nif.cfg_ack) break;
    end
    if (!nif.cfg_ack) check("t6_cfg_timeout", 0, 1);
    @(posedge clk); #1;
    nif.cfg_write = 1'b0; req_on = 0;
    wait_idle();
    check("t6_cfg_cycle", last_cfg, t + 5);
    check("t6_next_rd", last_rd, t + 7);

    // 6b: reset during RD abandons the op and empties the FIFO
    pot_save = pot_mem;
    @(posedge clk); #1;
    nif.ev_valid = 1'b1; nif.ev_idx = 5'd1;
    @(posedge clk); #1 nif.ev_idx = 5'd2;
    @(posedge clk); #1;
    nif.ev_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("t6_in_rd", 32'(nif.au_read), 1);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("t6_no_write", 32'(nif.au_write), 0);
    check("t6_busy", 32'(nif.busy), 0);
    check("t6_ev_ready", 32'(nif.ev_ready), 1);
    check("t6_spike_cnt", 32'(nif.spike_count), 0);
    repeat (3) @(negedge clk);
    check("t6_pot_kept", 32'(pot_mem), 32'(pot_save));

    // Randomized events interleaved with config writes
    for (int i = 0; i < 7; i++) cfg_req(6'(i), 16'($urandom_range(0, 400)));
    cfg_req(6'h07, 16'hFF00);
    cfg_req(6'h20, 16'($urandom_range(0, 900)));
    for (int r = 0; r < 25; r++) begin
      for (int c = 0; c < 15; c++) begin
        @(posedge clk); #1;
        nif.ev_valid = 1'($urandom_range(0, 1));
        nif.ev_idx   = 5'($urandom_range(0, 7));
      end
      #0 nif.ev_valid = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 0) cfg_req(6'h20, 16'($urandom_range(0, 1100)));
        else cfg_req(6'($urandom_range(0, 6)), 16'($urandom_range(0, 500)));
      end
    end
    nif.ev_valid = 1'b0;
    wait_idle();
    check("rnd_queue_empty", q_ref.size(), 0);
    check("rnd_spike_cnt", 32'(nif.spike_count), 32'(spikes_ref));
    check("rnd_pot", 32'(pot_mem), 32'(pot_ref));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
